// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    WB_DATA,
    RF_REQ,
    RF_DATA
  } state_t;

  // Widest address the field helpers handle; callers cast down to field width.
  localparam int ADDR_MAX_W = 64;
  typedef logic [ADDR_MAX_W-1:0] addr_wide_t;

  function automatic int calc_off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int calc_idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int words_per_line, input int lines);
    return addr_w - $clog2(words_per_line) - $clog2(lines);
  endfunction

  function automatic addr_wide_t field_mask(input int width);
    return (addr_wide_t'(1) << width) - addr_wide_t'(1);
  endfunction

  function automatic addr_wide_t get_off(input addr_wide_t addr, input int off_w);
    return addr & field_mask(off_w);
  endfunction

  function automatic addr_wide_t get_idx(input addr_wide_t addr, input int off_w, input int idx_w);
    return (addr >> off_w) & field_mask(idx_w);
  endfunction

  function automatic addr_wide_t get_tag(input addr_wide_t addr, input int off_w, input int idx_w,
                                         input int tag_w);
    return (addr >> (off_w + idx_w)) & field_mask(tag_w);
  endfunction

endpackage

// File: rtl/cache_line_ram.sv
// Cache data store: one byte-enabled write port, one registered read port.
// Each byte lane is its own array so byte enables map onto plain RAM writes.
// A read of the word being written in the same cycle returns the new bytes,
// which lets the final refill beat feed the replay lookup directly.
module cache_line_ram #(
  parameter int WORD_W = 64,
  parameter int DEPTH  = 2048,
  parameter int AW     = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W/8-1:0] be,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  localparam int BE_W = WORD_W / 8;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_lane_reg;

    // Byte-lane write with write-first forwarding on the registered read.
    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane_mem[waddr] <= wdata[8*gi +: 8];
      end
      if (we && be[gi] && (waddr == raddr)) begin
        rd_lane_reg <= wdata[8*gi +: 8];
      end else begin
        rd_lane_reg <= lane_mem[raddr];
      end
    end

    assign rdata[8*gi +: 8] = rd_lane_reg;
  end

endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped write-back, write-allocate cache controller with a single
// outstanding miss and line-burst write-back/refill to the next level.
module cache_ctrl_dm
  import cache_pkg::*;
#(
  parameter int WORD_W         = 64,
  parameter int WORDS_PER_LINE = 16,
  parameter int LINES          = 128,
  parameter int ADDR_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [WORD_W-1:0]     req_wdata,
  input  logic [WORD_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [WORD_W-1:0]     rsp_rdata,
  output logic                  rsp_hit,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [WORD_W-1:0]     mem_rdata
);

  localparam int OFF_W  = calc_off_w(WORDS_PER_LINE);
  localparam int IDX_W  = calc_idx_w(LINES);
  localparam int TAG_W  = calc_tag_w(ADDR_W, WORDS_PER_LINE, LINES);
  localparam int BE_W   = WORD_W / 8;
  localparam int RAM_AW = IDX_W + OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  state_t            state_reg, state_next;
  logic              ready_en_reg;
  logic              req_we_reg;
  logic [ADDR_W-1:0] req_addr_reg;
  logic [WORD_W-1:0] req_wdata_reg;
  logic [BE_W-1:0]   req_be_reg;
  logic              miss_flag_reg;
  logic [OFF_W-1:0]  beat_reg, beat_next;
  logic [LINES-1:0]  valid_reg, dirty_reg;
  logic [TAG_W-1:0]  tag_mem [LINES];

  logic [OFF_W-1:0]  cur_off, in_off;
  logic [IDX_W-1:0]  cur_idx, in_idx;
  logic [TAG_W-1:0]  cur_tag, victim_tag;
  logic              hit;
  logic [WORD_W-1:0] merged;

  logic              accept, set_dirty, set_miss, clear_valid, fill_done;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr, ram_raddr;
  logic [BE_W-1:0]   ram_be;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;

  assign cur_off    = OFF_W'(get_off(addr_wide_t'(req_addr_reg), OFF_W));
  assign cur_idx    = IDX_W'(get_idx(addr_wide_t'(req_addr_reg), OFF_W, IDX_W));
  assign cur_tag    = TAG_W'(get_tag(addr_wide_t'(req_addr_reg), OFF_W, IDX_W, TAG_W));
  assign in_off     = OFF_W'(get_off(addr_wide_t'(req_addr), OFF_W));
  assign in_idx     = IDX_W'(get_idx(addr_wide_t'(req_addr), OFF_W, IDX_W));
  assign victim_tag = tag_mem[cur_idx];
  assign hit        = valid_reg[cur_idx] && (victim_tag == cur_tag);

  // Store data merged over the resident word, byte by byte.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
    assign merged[8*gi +: 8] = req_be_reg[gi] ? req_wdata_reg[8*gi +: 8] : ram_rdata[8*gi +: 8];
  end

  cache_line_ram #(
    .WORD_W (WORD_W),
    .DEPTH  (LINES * WORDS_PER_LINE),
    .AW     (RAM_AW)
  ) u_line_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Next-state, handshake outputs and data-array write control.
  always_comb begin
    state_next    = state_reg;
    beat_next     = beat_reg;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rdata     = '0;
    rsp_hit       = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;
    ram_we        = 1'b0;
    ram_waddr     = {cur_idx, cur_off};
    ram_be        = '0;
    ram_wdata     = req_wdata_reg;
    accept        = 1'b0;
    set_dirty     = 1'b0;
    set_miss      = 1'b0;
    clear_valid   = 1'b0;
    fill_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = ready_en_reg;
        if (req_valid && ready_en_reg) begin
          accept     = 1'b1;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          rsp_valid  = 1'b1;
          rsp_hit    = !miss_flag_reg;
          state_next = IDLE;
          if (req_we_reg) begin
            rsp_rdata = merged;
            ram_we    = 1'b1;
            ram_be    = req_be_reg;
            set_dirty = 1'b1;
          end else begin
            rsp_rdata = ram_rdata;
          end
        end else begin
          set_miss   = 1'b1;
          beat_next  = '0;
          state_next = (valid_reg[cur_idx] && dirty_reg[cur_idx]) ? WB_REQ : RF_REQ;
        end
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {victim_tag, cur_idx, {OFF_W{1'b0}}};
        if (mem_req_ready) begin
          beat_next  = '0;
          state_next = WB_DATA;
        end
      end
      WB_DATA: begin
        mem_wvalid = 1'b1;
        mem_wdata  = ram_rdata;
        if (mem_wready) begin
          beat_next = beat_reg + OFF_W'(1);
          if (beat_reg == LAST_BEAT) begin
            clear_valid = 1'b1;
            state_next  = RF_REQ;
          end
        end
      end
      RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {cur_tag, cur_idx, {OFF_W{1'b0}}};
        if (mem_req_ready) begin
          beat_next  = '0;
          state_next = RF_DATA;
        end
      end
      RF_DATA: begin
        if (mem_rvalid) begin
          ram_we    = 1'b1;
          ram_waddr = {cur_idx, beat_reg};
          ram_be    = '1;
          ram_wdata = mem_rdata;
          beat_next = beat_reg + OFF_W'(1);
          if (beat_reg == LAST_BEAT) begin
            fill_done  = 1'b1;
            state_next = LOOKUP;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read address runs one cycle ahead of where the word is consumed:
  // the incoming request in IDLE, the requested word ahead of a lookup,
  // otherwise the next write-back beat.
  always_comb begin
    ram_raddr = {cur_idx, beat_next};
    if (state_reg == IDLE) begin
      ram_raddr = {in_idx, in_off};
    end else if (state_next == LOOKUP) begin
      ram_raddr = {cur_idx, cur_off};
    end
  end

  // Controller state, request capture and line valid/dirty bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ready_en_reg  <= 1'b0;
      req_we_reg    <= 1'b0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      req_be_reg    <= '0;
      miss_flag_reg <= 1'b0;
      beat_reg      <= '0;
      valid_reg     <= '0;
      dirty_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      beat_reg     <= beat_next;
      ready_en_reg <= 1'b1;
      if (accept) begin
        req_we_reg    <= req_we;
        req_addr_reg  <= req_addr;
        req_wdata_reg <= req_wdata;
        req_be_reg    <= req_be;
        miss_flag_reg <= 1'b0;
      end
      if (set_miss) begin
        miss_flag_reg <= 1'b1;
      end
      if (set_dirty) begin
        dirty_reg[cur_idx] <= 1'b1;
      end
      if (clear_valid) begin
        valid_reg[cur_idx] <= 1'b0;
      end
      if (fill_done) begin
        valid_reg[cur_idx] <= 1'b1;
        dirty_reg[cur_idx] <= 1'b0;
      end
    end
  end

  // Tag array is written only when a refill completes; never reset.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[cur_idx] <= cur_tag;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Directed bench for cache_ctrl_dm: bench-side memory responder, hand-computed
// expected responses, write-back contents, request addresses and latencies.
module tb_cache_ctrl_dm;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_hit;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [63:0] mem_wdata;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Per-transaction observations filled in by run_req.
  logic        got;
  logic        aborted;
  logic [63:0] obs_rdata;
  logic        obs_hit;
  int          lat;
  int          n_req;
  logic        mreq_we [4];
  logic [31:0] mreq_addr [4];
  int          rf_cnt;
  int          wb_cnt;
  logic [63:0] wb_data [16];
  logic        post_ready;
  logic        post_rsp;
  logic        wr_ph;

  cache_ctrl_dm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_hit       (rsp_hit),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_wvalid    (mem_wvalid),
    .mem_wready    (mem_wready),
    .mem_wdata     (mem_wdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request at a negedge and acts as the next-level memory until
  // the response (or an abort at refill beat abort_beat). All decisions are
  // taken on the falling edge and take effect at the following rising edge.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [7:0] be, input logic [63:0] base, input bit toggle_wr,
                         input int abort_beat);
    int  k;
    int  acc;
    bit  rf_on;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    got = 1'b0; aborted = 1'b0; lat = -1; n_req = 0; rf_cnt = 0; wb_cnt = 0;
    obs_rdata = '0; obs_hit = 1'b0; wr_ph = 1'b0;
    for (int i = 0; i < 16; i++) wb_data[i] = '0;
    k = 0; acc = -1; rf_on = 1'b0;
    while (!got && !aborted && k < 400) begin
      if (req_valid && req_ready && acc < 0) begin
        acc = k;
      end else if (acc >= 0) begin
        req_valid = 1'b0;
      end
      if (rsp_valid) begin
        got       = 1'b1;
        obs_rdata = rsp_rdata;
        obs_hit   = rsp_hit;
        lat       = k - acc;
      end
      if (rf_on && rf_cnt < 16) begin
        if (rf_cnt == abort_beat) begin
          rst_n      = 1'b0;
          mem_rvalid = 1'b0;
          aborted    = 1'b1;
        end else begin
          mem_rvalid = 1'b1;
          mem_rdata  = base + 64'(rf_cnt);
          rf_cnt++;
        end
      end else begin
        mem_rvalid = 1'b0;
      end
      if (mem_req_valid && !aborted) begin
        if (n_req < 4) begin
          mreq_we[n_req]   = mem_req_we;
          mreq_addr[n_req] = mem_req_addr;
        end
        n_req++;
        if (!mem_req_we) begin
          rf_on  = 1'b1;
          rf_cnt = 0;
        end
      end
      if (mem_wvalid) begin
        wr_ph      = ~wr_ph;
        mem_wready = toggle_wr ? wr_ph : 1'b1;
        if (mem_wready) begin
          if (wb_cnt < 16) wb_data[wb_cnt] = mem_wdata;
          wb_cnt++;
        end
      end else begin
        mem_wready = 1'b0;
      end
      if (!got && !aborted) begin
        @(negedge clk);
        k++;
      end
    end
    mem_rvalid = 1'b0;
    mem_wready = 1'b0;
    req_valid  = 1'b0;
    if (!aborted) begin
      check("rsp_seen", 64'(got), 64'(1));
      @(negedge clk);
      post_ready = req_ready;
      post_rsp   = rsp_valid;
      check("ready_after_rsp", 64'(post_ready), 64'(1));
      check("rsp_one_pulse", 64'(post_rsp), 64'(0));
    end
    $display("txn we=%0d addr=0x%0h rsp=%0d rdata=0x%0h hit=%0d lat=%0d mem_reqs=%0d wb=%0d rf=%0d abort=%0d",
             we, addr, got, obs_rdata, obs_hit, lat, n_req, wb_cnt, rf_cnt, aborted);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    mem_req_ready = 1'b1; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset: all outputs quiet, ready comes up one cycle after release.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
    check("rst_mem_wvalid", 64'(mem_wvalid), 64'(0));
    check("rst_rsp_rdata", rsp_rdata, 64'(0));
    check("rst_mem_req_addr", 64'(mem_req_addr), 64'(0));
    rst_n = 1'b1;
    check("ready_at_release", 64'(req_ready), 64'(0));
    @(negedge clk);
    check("ready_after_release", 64'(req_ready), 64'(1));

    // Cold load miss: refill of line 0x10, replay returns beat 3.
    run_req(1'b0, 32'h13, 64'h0, 8'h00, 64'h1000, 1'b0, -1);
    check("m1_nreq", 64'(n_req), 64'(1));
    check("m1_req_we", 64'(mreq_we[0]), 64'(0));
    check("m1_req_addr", 64'(mreq_addr[0]), 64'h10);
    check("m1_rf_beats", 64'(rf_cnt), 64'(16));
    check("m1_wb_beats", 64'(wb_cnt), 64'(0));
    check("m1_hit", 64'(obs_hit), 64'(0));
    check("m1_rdata", obs_rdata, 64'h1003);
    check("m1_latency", 64'(lat), 64'(19));

    // Load hit in the same line.
    run_req(1'b0, 32'h15, 64'h0, 8'h00, 64'h0, 1'b0, -1);
    check("h1_nreq", 64'(n_req), 64'(0));
    check("h1_hit", 64'(obs_hit), 64'(1));
    check("h1_rdata", obs_rdata, 64'h1005);
    check("h1_latency", 64'(lat), 64'(1));

    // Store hit, low four bytes enabled, merged with 0x1003.
    run_req(1'b1, 32'h13, 64'h1111_0000_1111_1111, 8'h0F, 64'h0, 1'b0, -1);
    check("s1_hit", 64'(obs_hit), 64'(1));
    check("s1_rdata", obs_rdata, 64'h0000_0000_1111_1111);
    check("s1_latency", 64'(lat), 64'(1));
    check("s1_nreq", 64'(n_req), 64'(0));

    run_req(1'b0, 32'h13, 64'h0, 8'h00, 64'h0, 1'b0, -1);
    check("l1_hit", 64'(obs_hit), 64'(1));
    check("l1_rdata", obs_rdata, 64'h0000_0000_1111_1111);

    // Conflict miss on a dirty line, wready toggling: write-back then refill.
    run_req(1'b0, 32'h813, 64'h0, 8'h00, 64'h2000, 1'b1, -1);
    check("d1_nreq", 64'(n_req), 64'(2));
    check("d1_wb_we", 64'(mreq_we[0]), 64'(1));
    check("d1_wb_addr", 64'(mreq_addr[0]), 64'h10);
    check("d1_rf_we", 64'(mreq_we[1]), 64'(0));
    check("d1_rf_addr", 64'(mreq_addr[1]), 64'h810);
    check("d1_wb_beats", 64'(wb_cnt), 64'(16));
    check("d1_wb_beat0", wb_data[0], 64'h1000);
    check("d1_wb_beat3", wb_data[3], 64'h0000_0000_1111_1111);
    check("d1_wb_beat15", wb_data[15], 64'h100F);
    check("d1_hit", 64'(obs_hit), 64'(0));
    check("d1_rdata", obs_rdata, 64'h2003);

    // Reset during refill beat 7, then the same load refills from scratch.
    run_req(1'b0, 32'h2013, 64'h0, 8'h00, 64'h5000, 1'b0, 7);
    check("ab_aborted", 64'(aborted), 64'(1));
    #1;
    check("ab_mem_req_valid", 64'(mem_req_valid), 64'(0));
    check("ab_req_ready", 64'(req_ready), 64'(0));
    check("ab_rsp_valid", 64'(rsp_valid), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ab_ready_back", 64'(req_ready), 64'(1));
    run_req(1'b0, 32'h2013, 64'h0, 8'h00, 64'h3000, 1'b0, -1);
    check("ab_nreq", 64'(n_req), 64'(1));
    check("ab_rf_we", 64'(mreq_we[0]), 64'(0));
    check("ab_rf_addr", 64'(mreq_addr[0]), 64'h2010);
    check("ab_rf_beats", 64'(rf_cnt), 64'(16));
    check("ab_hit", 64'(obs_hit), 64'(0));
    check("ab_rdata", obs_rdata, 64'h3003);

    // Store with no byte enables still dirties the line.
    run_req(1'b1, 32'h2013, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 64'h0, 1'b0, -1);
    check("z_hit", 64'(obs_hit), 64'(1));
    check("z_rdata", obs_rdata, 64'h3003);
    run_req(1'b0, 32'h813, 64'h0, 8'h00, 64'h4000, 1'b0, -1);
    check("z_nreq", 64'(n_req), 64'(2));
    check("z_wb_we", 64'(mreq_we[0]), 64'(1));
    check("z_wb_addr", 64'(mreq_addr[0]), 64'h2010);
    check("z_rf_addr", 64'(mreq_addr[1]), 64'h810);
    check("z_wb_beat0", wb_data[0], 64'h3000);
    check("z_wb_beat3", wb_data[3], 64'h3003);
    check("z_wb_beat15", wb_data[15], 64'h300F);
    check("z_hit_miss", 64'(obs_hit), 64'(0));
    check("z_rdata_miss", obs_rdata, 64'h4003);
    check("z_latency", 64'(lat), 64'(36));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
